// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB stage: default bundle layout and occupancy state.
package mem_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int BUNDLE_W = 3 + 2*DATA_W + REG_W;

    // One in-flight instruction as carried from MEM to WB (default widths).
    typedef struct packed {
        logic              jump;
        logic              memToReg;
        logic              regWrite;
        logic [DATA_W-1:0] readData;
        logic [DATA_W-1:0] aluResult;
        logic [REG_W-1:0]  writeRegister;
    } slotBundle_t;

    // Stage occupancy, encoded directly from {skidValid, mainValid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        MAIN  = 2'b01,
        FULL  = 2'b11
    } slotState_e;

endpackage

// File: rtl/mem_wb_skid_buffer_pipe_slot.sv
// One bundle register plus its valid bit; clear drops the beat but keeps the data.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Slot register: clear beats load so a squash can never be overridden by a refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data is reset too, not just valid, because every output must read 0 during reset.
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid_buffer.sv
// MEM/WB stage register with valid/ready handshake, optional skid slot, flush and stall counter.
module mem_wb_skid_buffer #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter bit SKID        = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic                   jumpI,
    input  logic                   memToRegI,
    input  logic                   regWriteI,
    input  logic [DATA_W-1:0]      readDataI,
    input  logic [DATA_W-1:0]      aluResultI,
    input  logic [REG_W-1:0]       writeRegisterI,
    output logic                   outValid,
    input  logic                   outReady,
    output logic                   jumpO,
    output logic                   memToRegO,
    output logic                   regWriteO,
    output logic [DATA_W-1:0]      readDataO,
    output logic [DATA_W-1:0]      aluResultO,
    output logic [REG_W-1:0]       writeRegisterO,
    output logic [STALL_CNT_W-1:0] stallCount
);
    import mem_wb_pkg::*;

    localparam int bundleW = 3 + 2*DATA_W + REG_W;

    logic [bundleW-1:0] inBundle, mainD, mainQ, skidQ;
    logic               mainValid, skidValid;
    logic               mainLoad, mainClear, skidLoad, skidClear;
    logic               accept, deliver;
    logic               jumpQ, regWriteQ;
    slotState_e         state;

    assign inBundle = {jumpI, memToRegI, regWriteI, readDataI, aluResultI, writeRegisterI};
    assign accept   = inValid && inReady;
    assign deliver  = mainValid && outReady;

    pipe_slot #(.W(bundleW)) mainSlot (
        .clk  (clk),
        .rst  (rst),
        .load (mainLoad),
        .clear(mainClear),
        .d    (mainD),
        .valid(mainValid),
        .q    (mainQ)
    );

    generate
        if (SKID) begin : gSkid
            // Registered ready: no combinational path from outReady back upstream.
            assign inReady = !skidValid;
            pipe_slot #(.W(bundleW)) skidSlot (
                .clk  (clk),
                .rst  (rst),
                .load (skidLoad),
                .clear(skidClear),
                .d    (inBundle),
                .valid(skidValid),
                .q    (skidQ)
            );
        end else begin : gNoSkid
            assign inReady   = outReady || !mainValid;
            assign skidValid = 1'b0;
            assign skidQ     = '0;
        end
    endgenerate

    // Slot steering: flush first, then skid-to-main promotion, then fill main, skid or drain.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves one unassigned (no latch).
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        mainD     = inBundle;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        if (flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else if (skidValid && deliver) begin
            mainLoad  = 1'b1;
            mainD     = skidQ;
            skidClear = 1'b1;
        end else if (accept && (!mainValid || deliver)) begin
            mainLoad = 1'b1;
        end else if (accept) begin
            skidLoad = 1'b1;
        end else if (deliver) begin
            mainClear = 1'b1;
        end
    end

    // Stall counter: counts edges where a held beat is refused, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= '0;
        end else if (mainValid && !outReady && (stallCount != '1)) begin
            stallCount <= stallCount + 1'b1;
        end
    end

    assign {jumpQ, memToRegO, regWriteQ, readDataO, aluResultO, writeRegisterO} = mainQ;
    assign outValid  = mainValid;
    assign jumpO     = jumpQ && mainValid;
    assign regWriteO = regWriteQ && mainValid;

    // Occupancy decode for waveforms and the consistency check below.
    always_comb begin
        state = slotState_e'({skidValid, mainValid});
    end

    // A skid beat can only exist behind a valid main beat.
    always @(posedge clk) begin
        if (!rst) begin
            assert (state inside {EMPTY, MAIN, FULL});
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_buffer.sv
// Randomised and directed checks of mem_wb_skid_buffer against a queue-based model.
module tb_mem_wb_skid_buffer;
    import mem_wb_pkg::*;

    localparam int NI = 3;  // 0: SKID=1, 1: SKID=0, 2: SKID=1 with 4-bit stall counter

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush    [NI];
    logic        inValid  [NI];
    logic        outReady [NI];
    logic        jumpI, memToRegI, regWriteI;
    logic [31:0] readDataI, aluResultI;
    logic [4:0]  writeRegisterI;

    logic        inReadyW  [NI];
    logic        outValidW [NI];
    logic        jumpOW    [NI];
    logic        memToRegOW[NI];
    logic        regWriteOW[NI];
    logic [31:0] readDataOW[NI];
    logic [31:0] aluOW     [NI];
    logic [4:0]  wrOW      [NI];
    logic [15:0] stall0, stall1;
    logic [3:0]  stall2;

    int total = 0;
    int bad   = 0;

    slotBundle_t mq [NI][$];
    slotBundle_t held [NI];
    int          stallM [NI];
    int          stallMax [NI] = '{65535, 65535, 15};
    bit          skidMode [NI] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    mem_wb_skid_buffer #(.DATA_W(32), .REG_W(5), .SKID(1'b1), .STALL_CNT_W(16)) dutSkid (
        .clk(clk), .rst(rst), .flush(flush[0]), .inValid(inValid[0]), .inReady(inReadyW[0]),
        .jumpI(jumpI), .memToRegI(memToRegI), .regWriteI(regWriteI), .readDataI(readDataI),
        .aluResultI(aluResultI), .writeRegisterI(writeRegisterI), .outValid(outValidW[0]),
        .outReady(outReady[0]), .jumpO(jumpOW[0]), .memToRegO(memToRegOW[0]), .regWriteO(regWriteOW[0]),
        .readDataO(readDataOW[0]), .aluResultO(aluOW[0]), .writeRegisterO(wrOW[0]), .stallCount(stall0)
    );

    mem_wb_skid_buffer #(.DATA_W(32), .REG_W(5), .SKID(1'b0), .STALL_CNT_W(16)) dutPlain (
        .clk(clk), .rst(rst), .flush(flush[1]), .inValid(inValid[1]), .inReady(inReadyW[1]),
        .jumpI(jumpI), .memToRegI(memToRegI), .regWriteI(regWriteI), .readDataI(readDataI),
        .aluResultI(aluResultI), .writeRegisterI(writeRegisterI), .outValid(outValidW[1]),
        .outReady(outReady[1]), .jumpO(jumpOW[1]), .memToRegO(memToRegOW[1]), .regWriteO(regWriteOW[1]),
        .readDataO(readDataOW[1]), .aluResultO(aluOW[1]), .writeRegisterO(wrOW[1]), .stallCount(stall1)
    );

    mem_wb_skid_buffer #(.DATA_W(32), .REG_W(5), .SKID(1'b1), .STALL_CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .flush(flush[2]), .inValid(inValid[2]), .inReady(inReadyW[2]),
        .jumpI(jumpI), .memToRegI(memToRegI), .regWriteI(regWriteI), .readDataI(readDataI),
        .aluResultI(aluResultI), .writeRegisterI(writeRegisterI), .outValid(outValidW[2]),
        .outReady(outReady[2]), .jumpO(jumpOW[2]), .memToRegO(memToRegOW[2]), .regWriteO(regWriteOW[2]),
        .readDataO(readDataOW[2]), .aluResultO(aluOW[2]), .writeRegisterO(wrOW[2]), .stallCount(stall2)
    );

    // ---------------- reference model ----------------
    function automatic slotBundle_t curIn();
        slotBundle_t b;
        b.jump          = jumpI;
        b.memToReg      = memToRegI;
        b.regWrite      = regWriteI;
        b.readData      = readDataI;
        b.aluResult     = aluResultI;
        b.writeRegister = writeRegisterI;
        return b;
    endfunction

    // Capacity 2 with registered ready, or capacity 1 with pass-through ready.
    function automatic bit modelReady(int i);
        if (skidMode[i]) return mq[i].size() < 2;
        return outReady[i] || (mq[i].size() == 0);
    endfunction

    function automatic logic [73:0] expVec(int i);
        bit          v = mq[i].size() > 0;
        slotBundle_t h = held[i];
        return {v, modelReady(i), h.jump & v, h.memToReg, h.regWrite & v,
                h.readData, h.aluResult, h.writeRegister};
    endfunction

    function automatic logic [73:0] actVec(int i);
        return {outValidW[i], inReadyW[i], jumpOW[i], memToRegOW[i], regWriteOW[i],
                readDataOW[i], aluOW[i], wrOW[i]};
    endfunction

    function automatic int stallAct(int i);
        case (i)
            0:       return int'(stall0);
            1:       return int'(stall1);
            default: return int'(stall2);
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            held[i]   = '0;
            stallM[i] = 0;
        end
    endtask

    // Advance one clock edge; the model applies the transfer rules to the pre-edge state.
    task automatic tick();
        bit          acc [NI];
        bit          del [NI];
        bit          stl [NI];
        slotBundle_t b = curIn();
        for (int i = 0; i < NI; i++) begin
            acc[i] = inValid[i] && modelReady(i);
            del[i] = (mq[i].size() > 0) && outReady[i];
            stl[i] = (mq[i].size() > 0) && !outReady[i];
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (stl[i] && stallM[i] < stallMax[i]) stallM[i]++;
                if (flush[i]) begin
                    mq[i].delete();
                end else begin
                    if (del[i]) void'(mq[i].pop_front());
                    if (acc[i]) mq[i].push_back(b);
                end
                if (mq[i].size() > 0) held[i] = mq[i][0];
            end
        end
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic driveIdle();
        for (int i = 0; i < NI; i++) begin
            flush[i]    = 1'b0;
            inValid[i]  = 1'b0;
            outReady[i] = 1'b1;
        end
    endtask

    task automatic driveData(logic [31:0] alu);
        jumpI          = alu[0];
        memToRegI      = alu[1];
        regWriteI      = alu[2];
        readDataI      = ~alu;
        aluResultI     = alu;
        writeRegisterI = alu[4:0];
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [73:0] zeroVec = {1'b0, 1'b1, 72'd0};
        driveIdle();
        applyReset();
        inValid[0] = 1'b1;
        outReady[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            driveData(32'h100 + k);
            tick();
        end
        settle();
        rst = 1'b1;
        modelReset();
        #1;
        for (int i = 0; i < NI; i++) begin
            total++;
            if (actVec(i) !== zeroVec) begin
                bad++;
                $display("FAIL reset_async[%0d]: got %h want %h", i, actVec(i), zeroVec);
            end
            total++;
            if (stallAct(i) != 0) begin
                bad++;
                $display("FAIL reset_stall[%0d]: got %0d want 0", i, stallAct(i));
            end
        end
        tick();
        rst = 1'b0;
        inValid[0] = 1'b0;
        settle();
        total++;
        if (actVec(0) !== zeroVec) begin
            bad++;
            $display("FAIL reset_after: got %h want %h", actVec(0), zeroVec);
        end
    endtask

    task automatic test_streaming(int i);
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        driveIdle();
        applyReset();
        inValid[i] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) driveData(vals[k]); else inValid[i] = 1'b0;
            settle();
            total++;
            if (inReadyW[i] !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready[%0d] k=%0d: got %b want 1", i, k, inReadyW[i]);
            end
            if (k > 0) begin
                total++;
                if (outValidW[i] !== 1'b1 || aluOW[i] !== vals[k-1]) begin
                    bad++;
                    $display("FAIL stream_data[%0d] k=%0d: got v=%b %h want v=1 %h",
                             i, k, outValidW[i], aluOW[i], vals[k-1]);
                end
            end
            tick();
        end
        settle();
        total++;
        if (outValidW[i] !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain[%0d]: got %b want 0", i, outValidW[i]);
        end
    endtask

    task automatic test_backpressure();
        driveIdle();
        applyReset();
        outReady[0] = 1'b0;
        inValid[0]  = 1'b1;
        driveData(32'hA);
        tick();
        driveData(32'hB);
        tick();
        inValid[0] = 1'b0;
        settle();
        total++;
        if (inReadyW[0] !== 1'b0 || outValidW[0] !== 1'b1 || aluOW[0] !== 32'hA) begin
            bad++;
            $display("FAIL bp_full: got rdy=%b v=%b %h want rdy=0 v=1 a", inReadyW[0], outValidW[0], aluOW[0]);
        end
        tick();
        outReady[0] = 1'b1;
        settle();
        total++;
        if (aluOW[0] !== 32'hA || actVec(0) !== expVec(0)) begin
            bad++;
            $display("FAIL bp_firstA: got %h want %h", actVec(0), expVec(0));
        end
        tick();
        settle();
        total++;
        if (outValidW[0] !== 1'b1 || aluOW[0] !== 32'hB || inReadyW[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_thenB: got v=%b %h rdy=%b want v=1 b rdy=1", outValidW[0], aluOW[0], inReadyW[0]);
        end
        tick();
        settle();
        total++;
        if (outValidW[0] !== 1'b0 || stall0 !== 16'd2) begin
            bad++;
            $display("FAIL bp_stall: got v=%b stall=%0d want v=0 stall=2", outValidW[0], stall0);
        end
    endtask

    task automatic test_flush();
        driveIdle();
        applyReset();
        outReady[0] = 1'b0;
        inValid[0]  = 1'b1;
        driveData(32'hA);
        tick();
        driveData(32'hB);
        tick();
        driveData(32'hC);
        regWriteI = 1'b1;
        jumpI     = 1'b1;
        flush[0]  = 1'b1;
        tick();
        flush[0]    = 1'b0;
        inValid[0]  = 1'b0;
        outReady[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            total++;
            if (outValidW[0] !== 1'b0 || regWriteOW[0] !== 1'b0 || jumpOW[0] !== 1'b0 || aluOW[0] !== 32'hA) begin
                bad++;
                $display("FAIL flush[%0d]: got v=%b rw=%b j=%b %h want 0 0 0 a",
                         k, outValidW[0], regWriteOW[0], jumpOW[0], aluOW[0]);
            end
            tick();
        end
    endtask

    task automatic test_noskid_ready();
        driveIdle();
        applyReset();
        inValid[1] = 1'b1;
        driveData(32'h55);
        tick();
        inValid[1]  = 1'b0;
        outReady[1] = 1'b0;
        settle();
        total++;
        if (inReadyW[1] !== 1'b0 || outValidW[1] !== 1'b1) begin
            bad++;
            $display("FAIL noskid_drop: got rdy=%b v=%b want rdy=0 v=1", inReadyW[1], outValidW[1]);
        end
        outReady[1] = 1'b1;
        #1;
        total++;
        if (inReadyW[1] !== 1'b1) begin
            bad++;
            $display("FAIL noskid_rise: got rdy=%b want 1", inReadyW[1]);
        end
        tick();
    endtask

    task automatic test_saturation();
        driveIdle();
        applyReset();
        outReady[2] = 1'b0;
        inValid[2]  = 1'b1;
        driveData(32'h77);
        tick();
        inValid[2] = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        settle();
        total++;
        if (stall2 !== 4'd15 || outValidW[2] !== 1'b1) begin
            bad++;
            $display("FAIL sat_stall: got stall=%0d v=%b want stall=15 v=1", stall2, outValidW[2]);
        end
    endtask

    task automatic test_random();
        driveIdle();
        applyReset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NI; i++) begin
                inValid[i]  = ($urandom_range(99) < 70);
                outReady[i] = ($urandom_range(99) < 60);
                flush[i]    = ($urandom_range(99) < 5);
            end
            jumpI          = 1'($urandom);
            memToRegI      = 1'($urandom);
            regWriteI      = 1'($urandom);
            readDataI      = $urandom;
            aluResultI     = $urandom;
            writeRegisterI = 5'($urandom);
            settle();
            for (int i = 0; i < NI; i++) begin
                total++;
                if (actVec(i) !== expVec(i)) begin
                    bad++;
                    $display("FAIL random_out[%0d] cyc=%0d: got %h want %h", i, c, actVec(i), expVec(i));
                end
                total++;
                if (stallAct(i) != stallM[i]) begin
                    bad++;
                    $display("FAIL random_stall[%0d] cyc=%0d: got %0d want %0d", i, c, stallAct(i), stallM[i]);
                end
            end
            tick();
        end
    endtask

    initial begin
        driveIdle();
        driveData(32'h0);
        modelReset();
        #3;
        rst = 1'b0;
        tick();
        test_reset();
        test_streaming(0);
        test_streaming(1);
        test_backpressure();
        test_flush();
        test_noskid_ready();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
